// File: rtl/instruction_fetch.sv
// Byte-serial fetch of one variable-length instruction (1/2/4/5 bytes) starting at eip.
// Assembles the bytes into a 40-bit word and hands it to decode with its length.
module instruction_fetch (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] eip,
  input  logic        fetch_start,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [39:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  output logic [3:0]  num_of_ope,
  output logic        illegal
);

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned INSTR_W   = 40;
  localparam int unsigned LEN_W     = 3;
  localparam int unsigned NOPE_W    = 4;
  localparam int unsigned MAX_BYTES = 5;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   base, base_d;
  logic [LEN_W-1:0]    cnt, cnt_d;
  logic [LEN_W-1:0]    len, len_d;
  logic [LEN_W-1:0]    len_now;
  logic [3:0]          dec;
  logic                launch;
  logic                busy_d, mem_req_d, instr_valid_d, illegal_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [INSTR_W-1:0]  instr_d;
  logic [NOPE_W-1:0]   num_of_ope_d;

  // Opcode length table; returns {illegal, length}
  function automatic logic [3:0] decode_len(input logic [7:0] op);
    logic [3:0] r;
    case (op) inside
      8'h90, [8'h40:8'h4F], 8'hC3:               r = {1'b0, 3'd1};
      [8'h70:8'h7F], 8'hEB, 8'h89, 8'h8B:        r = {1'b0, 3'd2};
      8'h66:                                     r = {1'b0, 3'd4};
      [8'hB8:8'hBF], 8'hE8, 8'hE9, 8'h05:        r = {1'b0, 3'd5};
      default:                                   r = {1'b1, 3'd1};
    endcase
    return r;
  endfunction

  always_comb begin
    state_d       = state;
    base_d        = base;
    cnt_d         = cnt;
    len_d         = len;
    instr_d       = instr;
    mem_req_d     = mem_req;
    mem_addr_d    = mem_addr;
    instr_valid_d = instr_valid;
    num_of_ope_d  = num_of_ope;
    illegal_d     = illegal;
    launch        = 1'b0;
    len_now       = len;
    dec           = decode_len(mem_rdata);

    case (state)
      IDLE: launch = fetch_start;
      REQ: begin
        if (mem_ack) begin
          for (int i = 0; i < int'(MAX_BYTES); i++) begin
            if (cnt == LEN_W'(i)) instr_d[i*8 +: 8] = mem_rdata;
          end
          if (cnt == '0) begin
            len_now   = dec[LEN_W-1:0];
            len_d     = dec[LEN_W-1:0];
            illegal_d = dec[3];
          end
          cnt_d = LEN_W'(cnt + 3'd1);
          if (LEN_W'(cnt + 3'd1) == len_now) begin
            state_d       = DONE;
            mem_req_d     = 1'b0;
            instr_valid_d = 1'b1;
            num_of_ope_d  = NOPE_W'(len_now);
          end else begin
            mem_addr_d = base + ADDR_W'(cnt + 3'd1);
          end
        end
      end
      DONE: begin
        if (instr_ack) begin
          instr_valid_d = 1'b0;
          num_of_ope_d  = '0;
          illegal_d     = 1'b0;
          state_d       = IDLE;
          launch        = fetch_start;
        end
      end
      default: state_d = IDLE;
    endcase

    // New fetch from IDLE or back-to-back from DONE
    if (launch) begin
      state_d    = REQ;
      base_d     = eip;
      cnt_d      = '0;
      instr_d    = '0;
      mem_req_d  = 1'b1;
      mem_addr_d = eip;
      illegal_d  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      base        <= '0;
      cnt         <= '0;
      len         <= '0;
      busy        <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      num_of_ope  <= '0;
      illegal     <= 1'b0;
    end else begin
      state       <= state_d;
      base        <= base_d;
      cnt         <= cnt_d;
      len         <= len_d;
      busy        <= busy_d;
      mem_req     <= mem_req_d;
      mem_addr    <= mem_addr_d;
      instr       <= instr_d;
      instr_valid <= instr_valid_d;
      num_of_ope  <= num_of_ope_d;
      illegal     <= illegal_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed cases then randomized fetches
// against a byte-array memory and a table-driven length model.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] eip = '0;
  logic        fetch_start = 1'b0;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic [39:0] instr;
  logic        instr_valid;
  logic        instr_ack = 1'b0;
  logic [3:0]  num_of_ope;
  logic        illegal;

  instruction_fetch dut (
    .clock(clock), .reset_n(reset_n), .eip(eip), .fetch_start(fetch_start),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_ack(instr_ack), .num_of_ope(num_of_ope), .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [39:0] instr;
    logic [3:0]  n;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  logic [7:0]  mem [logic [31:0]];
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned t_start = 0;
  int          ack_mode = 0;  // 0 zero-wait, 1 random, 2 every second cycle
  bit          alt = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [7:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // 0 means the opcode is not in the table
  function automatic int ref_len(input logic [7:0] op);
    if (op inside {8'h90, 8'hC3} || (op >= 8'h40 && op <= 8'h4F)) return 1;
    if ((op >= 8'h70 && op <= 8'h7F) || op inside {8'hEB, 8'h89, 8'h8B}) return 2;
    if (op == 8'h66) return 4;
    if ((op >= 8'hB8 && op <= 8'hBF) || op inside {8'hE8, 8'hE9, 8'h05}) return 5;
    return 0;
  endfunction

  task automatic load(input logic [31:0] a, input logic [39:0] w);
    for (int i = 0; i < 5; i++) mem[a + 32'(i)] = w[8*i +: 8];
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    int   l;
    l       = ref_len(rd(a));
    e.n     = 4'((l == 0) ? 1 : l);
    e.ill   = (l == 0);
    e.instr = '0;
    for (int i = 0; i < int'(e.n); i++) begin
      e.instr = e.instr | (40'(rd(a + 32'(i))) << (8 * i));
      addr_q.push_back(a + 32'(i));
    end
    exp_q.push_back(e);
    t_start = cyc + 1;
  endtask

  task automatic start(input logic [31:0] a);
    @(posedge clock); #1;
    alt         = 1'b1;
    eip         = a;
    fetch_start = 1'b1;
    push_exp(a);
    @(posedge clock); #1;
    fetch_start = 1'b0;
    eip         = $urandom;
  endtask

  task automatic finish(input int hold, input bit b2b, input logic [31:0] na, input logic [39:0] nw);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL valid_timeout actual=no_valid required=valid (t=%0t)", $time);
    end else if ((ack_mode == 0 || ack_mode == 2) && exp_q.size() > 0) begin
      chk("latency", 64'(cyc - t_start), 64'(exp_q[0].n) * ((ack_mode == 2) ? 2 : 1));
    end
    repeat (hold) begin @(posedge clock); #1; end
    instr_ack = 1'b1;
    if (b2b) begin
      load(na, nw);
      eip         = na;
      fetch_start = 1'b1;
      push_exp(na);
    end
    @(posedge clock); #1;
    chk("valid_after_ack", 64'(instr_valid), 64'(0));
    if (b2b) begin
      chk("b2b_mem_req", 64'(mem_req), 64'(1));
      chk("b2b_mem_addr", 64'(mem_addr), 64'(na));
      chk("b2b_busy", 64'(busy), 64'(1));
    end else begin
      chk("idle_busy", 64'(busy), 64'(0));
    end
    instr_ack   = 1'b0;
    fetch_start = 1'b0;
    eip         = $urandom;
  endtask

  task automatic gen(output logic [31:0] a, output logic [39:0] w);
    logic [7:0] ops [18];
    logic [7:0] op;
    ops = '{8'h90, 8'h40, 8'h4F, 8'hC3, 8'h70, 8'h7F, 8'hEB, 8'h89, 8'h8B,
            8'h66, 8'hB8, 8'hBF, 8'hE8, 8'hE9, 8'h05, 8'h0F, 8'h00, 8'hFF};
    a  = ($urandom % 4 == 0) ? 32'hFFFF_FFFC + 32'($urandom % 4) : 32'($urandom);
    op = ($urandom % 4 == 0) ? 8'($urandom) : ops[$urandom % 18];
    w  = {32'($urandom), op};
  endtask

  // Memory responder: checks each acknowledged read address against the model
  always @(posedge clock) begin
    bit give;
    #1;
    if (!reset_n) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      alt  = ~alt;
      give = (ack_mode == 0) || (ack_mode == 1 && ($urandom % 2) == 1) || (ack_mode == 2 && alt);
      mem_ack   = give;
      mem_rdata = give ? rd(mem_addr) : 8'($urandom);
      if (give) begin
        if (addr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_read actual=%0h required=no_read", mem_addr);
        end else begin
          chk("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
        end
      end
    end else begin
      mem_ack   = ($urandom % 4 == 0);
      mem_rdata = 8'($urandom);
    end
  end

  // Output monitor: compares the presented instruction every cycle it is held
  always @(negedge clock) begin
    if (reset_n) begin
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid actual=%0h required=none", instr);
        end else begin
          chk("instr", 64'(instr), 64'(exp_q[0].instr));
          chk("num_of_ope", 64'(num_of_ope), 64'(exp_q[0].n));
          chk("illegal", 64'(illegal), 64'(exp_q[0].ill));
          if (instr_ack) void'(exp_q.pop_front());
        end
      end else begin
        chk("num_idle", 64'(num_of_ope), 64'(0));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, na;
    logic [39:0] w, nw;
    bit          pend, b2b;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_instr", 64'(instr), 64'(0));
    chk("rst_valid", 64'(instr_valid), 64'(0));
    chk("rst_num", 64'(num_of_ope), 64'(0));
    chk("rst_illegal", 64'(illegal), 64'(0));
    reset_n = 1'b1;

    ack_mode = 0;
    load(32'h100, 40'h0000000090);
    start(32'h100);
    finish(0, 1'b0, '0, '0);

    ack_mode = 2;
    load(32'h200, 40'h12345678B8);
    start(32'h200);
    finish(1, 1'b0, '0, '0);

    ack_mode = 0;
    load(32'hFFFF_FFFE, 40'h00DDCCBB66);
    start(32'hFFFF_FFFE);
    finish(0, 1'b0, '0, '0);

    load(32'h0, 40'h000000000F);
    start(32'h0);
    finish(0, 1'b0, '0, '0);

    load(32'h10, 40'h00000005EB);
    start(32'h10);
    finish(3, 1'b1, 32'h7, 40'h0000000090);
    finish(0, 1'b0, '0, '0);

    load(32'h280, 40'h12345678B8);
    start(32'h280);
    repeat (3) begin @(posedge clock); #1; end
    chk("pre_reset_instr", 64'(instr), 64'h5678B8);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_mem_req", 64'(mem_req), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_instr", 64'(instr), 64'(0));
    chk("mid_rst_valid", 64'(instr_valid), 64'(0));
    chk("mid_rst_num", 64'(num_of_ope), 64'(0));
    repeat (2) @(posedge clock);
    #1;
    exp_q.delete();
    addr_q.delete();
    reset_n = 1'b1;
    repeat (4) begin @(posedge clock); #1; end
    chk("idle_after_stray_acks", 64'(busy), 64'(0));
    load(32'h300, 40'hAABBCCDD05);
    start(32'h300);
    finish(0, 1'b0, '0, '0);

    for (int phase = 1; phase >= 0; phase--) begin
      ack_mode = phase;
      pend = 1'b0;
      for (int t = 0; t < 30; t++) begin
        if (!pend) begin
          gen(a, w);
          load(a, w);
          start(a);
        end
        gen(na, nw);
        b2b = ($urandom % 3 == 0) && (t < 29);
        finish(int'($urandom % 4), b2b, na, nw);
        pend = b2b;
      end
    end

    repeat (3) @(posedge clock);
    chk("exp_q_empty", 64'(exp_q.size()), 64'(0));
    chk("addr_q_empty", 64'(addr_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
